// File: rtl/regfile_2w2r_pkg.sv
// Shared defaults for the two-write / two-read register file.
// Every rtl/ file imports this package so the defaults live in one place.
package regfile_2w2r_pkg;

    // Default data width in bits.
    localparam int RF_DEF_WIDTH = 32;

    // Default number of registers (power of two, at least 2).
    localparam int RF_DEF_DEPTH = 4;

    // Number of write ports and read ports.
    localparam int RF_NUM_WPORTS = 2;
    localparam int RF_NUM_RPORTS = 2;

endpackage : regfile_2w2r_pkg

// File: rtl/regfile_2w2r_scoreboard.sv
// Per-register busy scoreboard.
// A reservation marks a register as having a pending producer. Any write to
// that register clears the mark. The rbusy outputs look up the mark for each
// read address, with an optional early release when the producer is writing
// in this same cycle.
module regfile_2w2r_scoreboard
    import regfile_2w2r_pkg::*;
#(
    parameter int DEPTH    = RF_DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    // Write enables already have dropped zero-register writes removed.
    input  logic              we0_eff,
    input  logic              we1_eff,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic              rbusy0,
    output logic              rbusy1
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next-state busy bits. A reservation beats a write in the same cycle,
    // because the newly reserved producer has not written yet.
    always_comb begin
        // NOTE: every variable assigned here gets a value first. A path that
        // leaves it unassigned makes synthesis infer a latch.
        busy_d = busy_q;
        for (int a = 0; a < DEPTH; a++) begin
            logic set_a;
            logic clr_a;
            set_a = rsv_en && (rsv_addr == ADDR_W'(a))
                    && !(ZERO_REG && (a == 0));
            clr_a = (we0_eff && (waddr0 == ADDR_W'(a)))
                    || (we1_eff && (waddr1 == ADDR_W'(a)));
            if (set_a) begin
                busy_d[a] = 1'b1;
            end else if (clr_a) begin
                busy_d[a] = 1'b0;
            end
        end
    end

    // Busy flops. They clear as soon as reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before the edge.
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy lookup for each read port, with the optional same-cycle release.
    always_comb begin
        rbusy0 = busy_q[raddr0];
        rbusy1 = busy_q[raddr1];
        if (BYPASS) begin
            if (((we0_eff && (waddr0 == raddr0)) || (we1_eff && (waddr1 == raddr0)))
                && !(rsv_en && (rsv_addr == raddr0))) begin
                rbusy0 = 1'b0;
            end
            if (((we0_eff && (waddr0 == raddr1)) || (we1_eff && (waddr1 == raddr1)))
                && !(rsv_en && (rsv_addr == raddr1))) begin
                rbusy1 = 1'b0;
            end
        end
    end

endmodule : regfile_2w2r_scoreboard

// File: rtl/regfile_2w2r.sv
// Register file for the pipelined datapath, with two write ports and two read
// ports. It provides enable-muxed flop storage, write-to-read bypass, an
// optional hardwired zero register, and a busy scoreboard that issue logic
// uses to stall on pending producers.
module regfile_2w2r
    import regfile_2w2r_pkg::*;
#(
    parameter int WIDTH    = RF_DEF_WIDTH,
    parameter int DEPTH    = RF_DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rbusy0,
    output logic              rbusy1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              wr_conflict
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_conflict_q;
    logic             wr_conflict_d;
    logic             we0_eff;
    logic             we1_eff;

    // When the zero register is enabled, writes to address 0 are dropped.
    // Address inputs only matter when the matching enable is high.
    always_comb begin
        we0_eff = we0 && !(ZERO_REG && (waddr0 == '0));
        we1_eff = we1 && !(ZERO_REG && (waddr1 == '0));
    end

    // Write decode. Each register takes new data only when it is addressed,
    // and port 1 wins when both ports hit the same register.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (we1_eff && (waddr1 == ADDR_W'(i))) begin
                mem_d[i] = wdata1;
            end else if (we0_eff && (waddr0 == ADDR_W'(i))) begin
                mem_d[i] = wdata0;
            end
        end
    end

    // The collision flag uses the raw enables, so a collision on the zero
    // register is still reported.
    always_comb begin
        wr_conflict_d = we0 && we1 && (waddr0 == waddr1);
    end

    // Storage flops and the registered collision flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this array is plain flops, not a RAM macro, so it can
            // take the asynchronous clear. A RAM macro would not accept one.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    // Read muxes. The port 1 bypass check comes last, so port 1 has priority
    // when both write ports match the read address.
    always_comb begin
        rdata0 = mem_q[raddr0];
        rdata1 = mem_q[raddr1];
        if (BYPASS) begin
            if (we0_eff && (waddr0 == raddr0)) rdata0 = wdata0;
            if (we1_eff && (waddr1 == raddr0)) rdata0 = wdata1;
            if (we0_eff && (waddr0 == raddr1)) rdata1 = wdata0;
            if (we1_eff && (waddr1 == raddr1)) rdata1 = wdata1;
        end
        if (ZERO_REG && (raddr0 == '0)) rdata0 = '0;
        if (ZERO_REG && (raddr1 == '0)) rdata1 = '0;
    end

    regfile_2w2r_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .we0_eff  (we0_eff),
        .we1_eff  (we1_eff),
        .waddr0   (waddr0),
        .waddr1   (waddr1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr0   (raddr0),
        .raddr1   (raddr1),
        .rbusy0   (rbusy0),
        .rbusy1   (rbusy1)
    );

endmodule : regfile_2w2r

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r.
// It drives two builds from the same stimulus:
//   dut_a: default build (BYPASS=1, ZERO_REG=0)
//   dut_b: BYPASS=0, ZERO_REG=1
// Inputs change on the falling edge, and outputs are checked #1 later.
module tb_regfile_2w2r;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              we0, we1;
    logic [ADDR_W-1:0] waddr0, waddr1;
    logic [WIDTH-1:0]  wdata0, wdata1;
    logic [ADDR_W-1:0] raddr0, raddr1;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;

    logic [WIDTH-1:0]  a_rdata0, a_rdata1, b_rdata0, b_rdata1;
    logic              a_rbusy0, a_rbusy1, b_rbusy0, b_rbusy1;
    logic              a_conf, b_conf;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_2w2r #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .rbusy0(a_rbusy0), .rbusy1(a_rbusy1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wr_conflict(a_conf)
    );

    regfile_2w2r #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .rbusy0(b_rbusy0), .rbusy1(b_rbusy1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wr_conflict(b_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_writes();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr0 = '0; raddr1 = '0; rsv_addr = '0;

        // 1: Reset is held for 20 ns. Every address must read 0 and not busy.
        #20;
        for (int i = 0; i < DEPTH; i++) begin
            raddr0 = ADDR_W'(i);
            raddr1 = ADDR_W'(DEPTH - 1 - i);
            #1;
            check($sformatf("rst_a_rd0_%0d", i), a_rdata0, 32'h0);
            check($sformatf("rst_a_rd1_%0d", i), a_rdata1, 32'h0);
            check($sformatf("rst_a_bz0_%0d", i), 32'(a_rbusy0), 32'h0);
            check($sformatf("rst_b_rd0_%0d", i), b_rdata0, 32'h0);
            check($sformatf("rst_b_bz1_%0d", i), 32'(b_rbusy1), 32'h0);
        end
        check("rst_a_conf", 32'(a_conf), 32'h0);
        check("rst_b_conf", 32'(b_conf), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // 2: Write FFFFFFFF to address 0, then read addresses 0 and 3.
        //    The zero-register build drops the write.
        we0 = 1'b1; waddr0 = 2'd0; wdata0 = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_writes();
        raddr0 = 2'd0; raddr1 = 2'd3;
        #1;
        check("wr_a_rd0", a_rdata0, 32'hFFFF_FFFF);
        check("wr_a_rd1", a_rdata1, 32'h0000_0000);
        check("wr_b_rd0_zero", b_rdata0, 32'h0000_0000);

        // 3: Both ports write address 2, and port 1 must win.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 2'd2; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 2'd2; wdata1 = 32'hAAAA_AAAA;
        raddr0 = 2'd2;
        #1;
        check("col_a_bypass_p1", a_rdata0, 32'hAAAA_AAAA);
        check("col_b_nobypass", b_rdata0, 32'h0000_0000);
        check("col_a_conf_pre", 32'(a_conf), 32'h0);
        @(negedge clk);
        idle_writes();
        #1;
        check("col_a_rd", a_rdata0, 32'hAAAA_AAAA);
        check("col_b_rd", b_rdata0, 32'hAAAA_AAAA);
        check("col_a_conf", 32'(a_conf), 32'h1);
        check("col_b_conf", 32'(b_conf), 32'h1);
        @(negedge clk);
        #1;
        check("col_a_conf_clr", 32'(a_conf), 32'h0);
        check("col_b_conf_clr", 32'(b_conf), 32'h0);

        // 4: Bypass. Port 1 writes address 1 while port 0 reads it.
        @(negedge clk);
        we1 = 1'b1; waddr1 = 2'd1; wdata1 = 32'h1234_5678;
        raddr0 = 2'd1;
        #1;
        check("byp_a_new", a_rdata0, 32'h1234_5678);
        check("byp_b_old", b_rdata0, 32'h0000_0000);
        @(negedge clk);
        idle_writes();
        #1;
        check("byp_a_after", a_rdata0, 32'h1234_5678);
        check("byp_b_after", b_rdata0, 32'h1234_5678);

        // 5: Scoreboard. Reserve, then write, then reserve and write together.
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 2'd3;
        raddr1 = 2'd3;
        #1;
        check("sb_a_pre", 32'(a_rbusy1), 32'h0);
        @(negedge clk);
        idle_writes();
        #1;
        check("sb_a_set", 32'(a_rbusy1), 32'h1);
        check("sb_b_set", 32'(b_rbusy1), 32'h1);
        @(negedge clk);
        we0 = 1'b1; waddr0 = 2'd3; wdata0 = 32'hCAFE_F00D;
        #1;
        check("sb_a_early_rel", 32'(a_rbusy1), 32'h0);
        check("sb_b_still", 32'(b_rbusy1), 32'h1);
        @(negedge clk);
        idle_writes();
        #1;
        check("sb_a_clr", 32'(a_rbusy1), 32'h0);
        check("sb_b_clr", 32'(b_rbusy1), 32'h0);
        check("sb_a_data", a_rdata1, 32'hCAFE_F00D);
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 2'd3;
        we1 = 1'b1; waddr1 = 2'd3; wdata1 = 32'h0000_0055;
        @(negedge clk);
        idle_writes();
        #1;
        check("sb_a_rsvwr", 32'(a_rbusy1), 32'h1);
        check("sb_b_rsvwr", 32'(b_rbusy1), 32'h1);
        check("sb_b_rsvwr_data", b_rdata1, 32'h0000_0055);
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 2'd3;
        @(negedge clk);
        idle_writes();
        #1;
        check("sb_a_rerserve", 32'(a_rbusy1), 32'h1);

        // 6: Zero register. Write and reserve address 0 with a collision.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 2'd0; wdata0 = 32'hDEAD_BEEF;
        we1 = 1'b1; waddr1 = 2'd0; wdata1 = 32'hDEAD_BEEF;
        rsv_en = 1'b1; rsv_addr = 2'd0;
        raddr0 = 2'd0;
        @(negedge clk);
        idle_writes();
        #1;
        check("z_b_rd", b_rdata0, 32'h0);
        check("z_b_bz", 32'(b_rbusy0), 32'h0);
        check("z_b_conf", 32'(b_conf), 32'h1);
        check("z_a_rd", a_rdata0, 32'hDEAD_BEEF);
        check("z_a_bz", 32'(a_rbusy0), 32'h1);

        // Address inputs go unknown while the enables are low. State must not change.
        @(negedge clk);
        waddr0 = 'x; waddr1 = 'x; rsv_addr = 'x;
        raddr0 = 2'd2;
        @(negedge clk);
        waddr0 = '0; waddr1 = '0; rsv_addr = '0;
        #1;
        check("x_a_rd2", a_rdata0, 32'hAAAA_AAAA);
        check("x_b_rd2", b_rdata0, 32'hAAAA_AAAA);

        // Reset asserted mid-burst. The write in flight is lost.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 2'd1; wdata0 = 32'h7777_7777;
        #2;
        reset = 1'b0;
        @(negedge clk);
        idle_writes();
        for (int i = 0; i < DEPTH; i++) begin
            raddr0 = ADDR_W'(i);
            raddr1 = ADDR_W'(i);
            #1;
            check($sformatf("mrst_a_rd_%0d", i), a_rdata0, 32'h0);
            check($sformatf("mrst_b_rd_%0d", i), b_rdata1, 32'h0);
            check($sformatf("mrst_a_bz_%0d", i), 32'(a_rbusy1), 32'h0);
        end
        check("mrst_a_conf", 32'(a_conf), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        we0 = 1'b1; waddr0 = 2'd1; wdata0 = 32'h0BAD_F00D;
        raddr0 = 2'd1;
        @(negedge clk);
        idle_writes();
        #1;
        check("post_rst_a_wr", a_rdata0, 32'h0BAD_F00D);
        check("post_rst_b_wr", b_rdata0, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_2w2r
